// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - host-side byte request and serial output bundle for the UART transmitter
interface uart_transmitter_if;
    logic       txEn;
    logic       txStart;
    logic [7:0] in_data;
    logic       tx;
    logic       txBusy;
    logic       txDone;

    modport master (
        output txEn,
        output txStart,
        output in_data,
        input  tx,
        input  txBusy,
        input  txDone
    );

    modport slave (
        input  txEn,
        input  txStart,
        input  in_data,
        output tx,
        output txBusy,
        output txDone
    );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1/8O1/8E1 UART serialiser with registered outputs
module uart_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_transmitter_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_EVN = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_baud_cnt;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_tx;
    logic           r_busy;
    logic           r_done;

    state_t         w_state_next;
    logic [CW-1:0]  w_cnt_next;
    logic [2:0]     w_idx_next;
    logic [7:0]     w_shift_next;
    logic           w_tx_next;
    logic           w_busy_next;
    logic           w_done_next;
    logic           w_baud_wrap;
    logic           w_accept;
    logic           w_par_bit;
    logic [2:0]     w_idx_inc;

    assign w_baud_wrap = (r_baud_cnt == CW'(DIV - 1));
    assign w_accept    = bus.txEn && bus.txStart;
    // Parity always comes from the latched byte so live input changes cannot leak in.
    assign w_par_bit   = PAR_EVN ? (^r_shift) : (~^r_shift);
    assign w_idx_inc   = r_bit_idx + 3'd1;

    // Next-state and next-output logic; every output is computed here and then registered.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_baud_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                    w_state_next = S_DATA;
                end else begin
                    w_cnt_next = r_baud_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    w_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        if (PAR_EN) begin
                            w_tx_next    = w_par_bit;
                            w_state_next = S_PARITY;
                        end else begin
                            w_tx_next    = 1'b1;
                            w_state_next = S_STOP;
                        end
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_tx_next  = r_shift[w_idx_inc];
                    end
                end else begin
                    w_cnt_next = r_baud_cnt + CW'(1);
                end
            end
            S_PARITY: begin
                if (w_baud_wrap) begin
                    w_cnt_next   = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_STOP;
                end else begin
                    w_cnt_next = r_baud_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_wrap) begin
                    w_cnt_next   = '0;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_baud_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase

        // Accepting on the final stop clock lets the next start bit follow with no idle gap.
        if (w_accept && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_wrap))) begin
            w_state_next = S_START;
            w_cnt_next   = '0;
            w_idx_next   = 3'd0;
            w_shift_next = bus.in_data;
            w_tx_next    = 1'b0;
            w_busy_next  = 1'b1;
        end
    end

    // State and output registers; reset aborts any frame and returns the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_cnt_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign bus.tx     = r_tx;
    assign bus.txBusy = r_busy;
    assign bus.txDone = r_done;
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART transmit side, the counterpart of the existing `receiver` block.
- Serialises one byte per request as an 8N1 frame (optionally 8E1/8O1): start bit, 8 data bits LSB first, optional parity, one stop bit.
- Default timing is 115200 baud from the 50 MHz system clock (8680 ns per bit), so `tx` can be looped directly into `receiver.rx`.
- Sits between the host-side byte source and the serial pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even. Any other value behaves as 0.
- Derived constant (not overridable): DIV = CLK_FREQ / BAUD_RATE with integer truncation. At defaults DIV = 434 clocks per bit. The baud counter width is $clog2(DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- txEn  input  1  transmit enable; gates acceptance of new frames only.
- txStart  input  1  request strobe, sampled each cycle.
- in_data  input  8  byte to send; sampled only on the accept cycle.
- tx  output  1  serial line; idles high.
- txBusy  output  1  high while a frame is being shifted out.
- txDone  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, txBusy=0, txDone=0, FSM=IDLE.
  - Baud counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame with no txDone; tx returns high at once.
- FSM states and transitions:
  - IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - PARITY state is visited only when PARITY is 1 or 2.
- Accept:
  - In IDLE, if txEn=1 and txStart=1 at a rising edge, latch in_data into the shift register and go to START.
  - From that same edge, tx=0 and txBusy=1.
  - Latency from accept edge to start bit on tx: 0 cycles (all outputs are registered).
- Bit timing:
  - Every bit (start, data, parity, stop) holds tx stable for exactly DIV clocks.
  - The baud counter runs 0..DIV-1; the state or bit advances when it wraps.
  - No fractional correction.
- DATA state:
  - Sends in_data[0] first through in_data[7]; the bit index runs 0..7, then leaves DATA.
- PARITY state:
  - Even mode sends ^data. Odd mode sends ~^data.
  - Parity is computed from the latched byte, not the live input.
- STOP state:
  - tx=1 for DIV clocks.
  - On the final clock, transition to IDLE; on that edge txBusy=0 and txDone=1 for exactly one cycle.
- Frame length from accept edge to the txDone edge: 10·DIV clocks with no parity, 11·DIV with parity.
- Back-to-back frames: txStart=1 with txEn=1 in the cycle txDone is high is accepted. The next start bit immediately follows the stop bit with no extra idle time.
- txStart while txBusy=1 is ignored; there is no queuing.
- in_data changes after the accept edge have no effect on the frame in progress.
- txEn deasserted mid-frame: the current frame completes normally. txEn only blocks new accepts.
- txStart held high continuously with txEn=1 transmits consecutive frames.
- Outputs are glitch-free: tx comes directly from a flop.

Test Plan:
- Reset, then txEn=1 and a 1-cycle txStart with in_data=8'hB5:
  - tx falls on the accept edge.
  - Bit sequence 0,1,0,1,0,1,1,0,1,1 with each level held 434 clocks (8680 ns).
  - txBusy high for 4340 clocks; txDone pulses once, 4340 clocks after accept.
- Loopback of tx into a `receiver` instance for bytes 8'h00, 8'hFF, 8'hB5, 8'h5A:
  - receiver.out_data matches each byte on its rxDone.
- txStart pulsed mid-frame with a different in_data, and in_data toggled mid-frame:
  - Transmitted bits match only the originally latched byte.
  - Exactly one txDone is produced.
- txStart held high for two frames (8'hA5 then 8'h3C, with in_data switched during the first frame):
  - Second start bit begins on the txDone cycle.
  - Total time is 8680 clocks; both bytes are correct.
- PARITY=2 with 8'hB5 (five ones):
  - Parity bit is 1 and the frame is 11·434 clocks.
  - Repeating with PARITY=1 gives a parity bit of 0.
- rst_n asserted low at clock 2000 of a frame:
  - tx=1 and txBusy=0 immediately, with no txDone.
  - After release, a new 8'h81 frame transmits correctly.
- txEn=0 with txStart=1:
  - No activity; tx stays 1 for 5000 clocks.
